alu_arbiter: RTL and testbench

Shares the single ArithmeticLogicUnit between several requesters, e.g. the execute stage and the load/store address generator. Each cycle it picks one requester by round-robin and drives that requester's one-hot ALU operation and operands into the ALU. It captures the ALU result in a one-entry result register and returns it with valid/ready handshakes. It sits between the operand-wiring logic of each requester and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NUM_REQ requesters with a
// one-entry registered result. Define ALU_ARB_LOCK_EN for bounded grant locking.
module alu_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int OP_W     = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OP_W-1:0]     req_op,
  input  logic [NUM_REQ*DATA_W-1:0]   req_in1,
  input  logic [NUM_REQ*DATA_W-1:0]   req_in2,
  input  logic [NUM_REQ*DATA_W-1:0]   req_in1_b,
  input  logic [NUM_REQ*DATA_W-1:0]   req_in2_b,
  input  logic [NUM_REQ-1:0]          req_lock,
  output logic [OP_W-1:0]             alu_op,
  output logic [DATA_W-1:0]           alu_in1,
  output logic [DATA_W-1:0]           alu_in2,
  output logic [DATA_W-1:0]           alu_in1_b,
  output logic [DATA_W-1:0]           alu_in2_b,
  input  logic [DATA_W-1:0]           alu_out,
  input  logic                        alu_out_b,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_out,
  output logic                        rsp_out_b,
  input  logic [NUM_REQ-1:0]          rsp_ready
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  logic              rsp_out_b_q, rsp_out_b_d;

  logic [ID_W-1:0]   gnt_idx, gnt_inc, cand;
  logic              gnt_found, rsp_drain, can_accept, accept;
  int unsigned       idx;

`ifdef ALU_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d, lock_next;
  logic              gnt_lock;
`else
  logic              unused_lock;
  assign unused_lock = ^req_lock ^ (MAX_LOCK == 0);
`endif

  // First valid requester scanning from ptr upward, wrapping at NUM_REQ.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_idx   = cand;
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_drain = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rsp_id_q == ID_W'(i)) rsp_drain = rsp_ready[i];
    end
  end

  // A held result that drains this cycle frees the register for a refill.
  assign can_accept = !rsp_valid_q || rsp_drain;
  assign accept     = gnt_found && can_accept;
  assign gnt_inc    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    alu_op    = '0;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_in1_b = '0;
    alu_in2_b = '0;
`ifdef ALU_ARB_LOCK_EN
    gnt_lock  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && gnt_idx == ID_W'(i)) begin
        req_ready[i] = can_accept;
        alu_op       = req_op[i*OP_W +: OP_W];
        alu_in1      = req_in1[i*DATA_W +: DATA_W];
        alu_in2      = req_in2[i*DATA_W +: DATA_W];
        alu_in1_b    = req_in1_b[i*DATA_W +: DATA_W];
        alu_in2_b    = req_in2_b[i*DATA_W +: DATA_W];
`ifdef ALU_ARB_LOCK_EN
        gnt_lock     = req_lock[i];
`endif
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_out_b_d = rsp_out_b_q;
`ifdef ALU_ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
    lock_next   = '0;
`endif
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_out_d   = alu_out;
      rsp_out_b_d = alu_out_b;
      ptr_d       = gnt_inc;
`ifdef ALU_ARB_LOCK_EN
      // rsp_id_q still names the previous acceptor, which identifies a locked run.
      lock_cnt_d = '0;
      if (gnt_lock) begin
        lock_next = (gnt_idx == rsp_id_q && lock_cnt_q != '0) ? lock_cnt_q + 1'b1
                                                              : CNT_W'(1);
        if (lock_next != CNT_W'(MAX_LOCK)) begin
          ptr_d      = gnt_idx;
          lock_cnt_d = lock_next;
        end
      end
`endif
    end else if (rsp_valid_q && rsp_drain) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_out_b_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_out_b_q <= rsp_out_b_d;
`ifdef ALU_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_out_b = rsp_out_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a per-cycle reference model of the
// arbiter plus hand-computed literal checks. Honours ALU_ARB_LOCK_EN.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int OPW  = 13;
  localparam int DW   = 32;
  localparam int MAXL = 4;

  localparam logic [12:0] OP_ADD   = 13'h0001;
  localparam logic [12:0] OP_SUB   = 13'h0002;
  localparam logic [12:0] OP_AND   = 13'h0004;
  localparam logic [12:0] OP_OR    = 13'h0008;
  localparam logic [12:0] OP_XOR   = 13'h0010;
  localparam logic [12:0] OP_EQ_B  = 13'h0400;
  localparam logic [12:0] OP_SLT_B = 13'h0800;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_lock, rsp_ready;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ*DW-1:0]   req_in1, req_in2, req_in1_b, req_in2_b;
  logic [OPW-1:0]       alu_op;
  logic [DW-1:0]        alu_in1, alu_in2, alu_in1_b, alu_in2_b, alu_out;
  logic                 alu_out_b;
  logic                 rsp_valid, rsp_out_b;
  logic [0:0]           rsp_id;
  logic [DW-1:0]        rsp_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NREQ), .OP_W(OPW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2), .req_in1_b(req_in1_b), .req_in2_b(req_in2_b),
    .req_lock(req_lock),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_in1_b(alu_in1_b), .alu_in2_b(alu_in2_b),
    .alu_out(alu_out), .alu_out_b(alu_out_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_out_b(rsp_out_b),
    .rsp_ready(rsp_ready)
  );

  function automatic logic [31:0] alu_f(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[0]) return a + b;
    if (op[1]) return a - b;
    if (op[2]) return a & b;
    if (op[3]) return a | b;
    if (op[4]) return a ^ b;
    return 32'h0;
  endfunction

  function automatic logic alu_fb(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[10]) return a == b;
    if (op[11]) return $signed(a) < $signed(b);
    if (op[12]) return a < b;
    return 1'b0;
  endfunction

  assign alu_out   = alu_f(alu_op, alu_in1, alu_in2);
  assign alu_out_b = alu_fb(alu_op, alu_in1_b, alu_in2_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [12:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ab, input logic [31:0] bb, input logic lk);
    req_valid[i]           = v;
    req_op[i*OPW +: OPW]   = op;
    req_in1[i*DW +: DW]    = a;
    req_in2[i*DW +: DW]    = b;
    req_in1_b[i*DW +: DW]  = ab;
    req_in2_b[i*DW +: DW]  = bb;
    req_lock[i]            = lk;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: checked on every falling edge, then advanced to the next cycle.
  initial begin : model
    int          m_ptr, m_id, m_cnt, g, c;
    bit          m_vld, can;
    logic [31:0] m_out;
    logic        m_outb;
    logic [1:0]  e_rdy;
    logic [12:0] e_op;
    m_ptr = 0; m_id = 0; m_cnt = 0; m_vld = 0; m_out = 0; m_outb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_id = 0; m_cnt = 0; m_vld = 0; m_out = 0; m_outb = 0;
      end else begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[c]) g = c;
        end
        can   = !m_vld || rsp_ready[m_id];
        e_rdy = (g >= 0 && can) ? 2'(1 << g) : 2'b00;
        e_op  = (g >= 0) ? req_op[g*OPW +: OPW] : 13'h0;
        chk("m_ready", 32'(req_ready), 32'(e_rdy));
        chk("m_alu_op", 32'(alu_op), 32'(e_op));
        chk("m_alu_in1", alu_in1, (g >= 0) ? req_in1[g*DW +: DW] : 32'h0);
        chk("m_alu_in2", alu_in2, (g >= 0) ? req_in2[g*DW +: DW] : 32'h0);
        chk("m_alu_in1_b", alu_in1_b, (g >= 0) ? req_in1_b[g*DW +: DW] : 32'h0);
        chk("m_alu_in2_b", alu_in2_b, (g >= 0) ? req_in2_b[g*DW +: DW] : 32'h0);
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("m_rsp_out", rsp_out, m_out);
        chk("m_rsp_out_b", 32'(rsp_out_b), 32'(m_outb));
        if (g >= 0 && can) begin
          m_out  = alu_f(req_op[g*OPW +: OPW], req_in1[g*DW +: DW], req_in2[g*DW +: DW]);
          m_outb = alu_fb(req_op[g*OPW +: OPW], req_in1_b[g*DW +: DW], req_in2_b[g*DW +: DW]);
          m_ptr  = (g + 1) % NREQ;
`ifdef ALU_ARB_LOCK_EN
          if (req_lock[g]) begin
            m_cnt = (g == m_id && m_cnt > 0) ? m_cnt + 1 : 1;
            if (m_cnt == MAXL) m_cnt = 0;
            else m_ptr = g;
          end else begin
            m_cnt = 0;
          end
`endif
          m_id  = g;
          m_vld = 1;
        end else if (m_vld && rsp_ready[m_id]) begin
          m_vld = 0;
        end
      end
    end
  end

  logic [1:0] exp_seq [6];

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_lock = '0; rsp_ready = '0; req_op = '0;
    req_in1 = '0; req_in2 = '0; req_in1_b = '0; req_in2_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_out", rsp_out, 32'd0);
    chk("rst_out_b", 32'(rsp_out_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;

    // Round-robin alternation with both requesters valid.
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b1, OP_SUB, 32'd20, 32'd3, 32'd0, 32'd0, 1'b0);
    rsp_ready = 2'b11;
    #1 chk("rr_g0", 32'(req_ready), 32'b01);
    step; #1;
    chk("rr_g1", 32'(req_ready), 32'b10);
    chk("add_out", rsp_out, 32'd12);
    chk("add_id", 32'(rsp_id), 32'd0);
    step; #1;
    chk("rr_g2", 32'(req_ready), 32'b01);
    chk("sub_out", rsp_out, 32'd17);
    chk("sub_id", 32'(rsp_id), 32'd1);
    step; #1;
    chk("rr_g3", 32'(req_ready), 32'b10);
    chk("rr_id3", 32'(rsp_id), 32'd0);

    // Nothing valid: ALU inputs gated to zero, result drains.
    step;
    set_req(0, 1'b0, OP_ADD, 32'd5, 32'd7, 32'd9, 32'd9, 1'b0);
    set_req(1, 1'b0, OP_SUB, 32'd20, 32'd3, 32'd9, 32'd9, 1'b0);
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_op", 32'(alu_op), 32'd0);
    chk("idle_in1", alu_in1, 32'd0);
    chk("idle_in2_b", alu_in2_b, 32'd0);
    chk("idle_valid", 32'(rsp_valid), 32'd1);
    step; #1;
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_hold", rsp_out, 32'd17);

    // Result blocked for 3 cycles, then drain and refill together.
    set_req(0, 1'b1, OP_AND, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0);
    rsp_ready = 2'b00;
    #1 chk("and_ready", 32'(req_ready), 32'b01);
    step;
    set_req(0, 1'b0, OP_AND, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b1, OP_OR, 32'h0F, 32'hF0, 32'd0, 32'd0, 1'b0);
    rsp_ready = 2'b10;
    #1;
    chk("and_out", rsp_out, 32'h0000_F000);
    chk("blk_ready0", 32'(req_ready), 32'd0);
    chk("blk_op", 32'(alu_op), 32'(OP_OR));
    repeat (2) begin
      step; #1;
      chk("blk_ready", 32'(req_ready), 32'd0);
      chk("blk_hold", rsp_out, 32'h0000_F000);
      chk("blk_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 2'b01;
    #1 chk("unblk_ready", 32'(req_ready), 32'b10);
    step;
    set_req(1, 1'b1, OP_SLT_B, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    rsp_ready = 2'b11;
    #1;
    chk("or_out", rsp_out, 32'h0000_00FF);
    chk("or_id", 32'(rsp_id), 32'd1);
    chk("slt_ready", 32'(req_ready), 32'b10);
    chk("slt_pre_b", 32'(rsp_out_b), 32'd0);
    step; #1;
    chk("slt_b", 32'(rsp_out_b), 32'd1);
    chk("slt_id", 32'(rsp_id), 32'd1);

    // Asynchronous reset while a result is held.
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_out_b", 32'(rsp_out_b), 32'd0);
    chk("arst_id", 32'(rsp_id), 32'd0);
    step;
    set_req(0, 1'b1, OP_XOR, 32'd3, 32'd5, 32'd4, 32'd4, 1'b1);
    set_req(1, 1'b1, OP_EQ_B, 32'd1, 32'd1, 32'd4, 32'd4, 1'b0);
    rst_n = 1'b1;
    #1;

`ifdef ALU_ARB_LOCK_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("lock_g%0d", c), 32'(req_ready), 32'(exp_seq[c]));
      step; #1;
    end

    set_req(0, 1'b0, OP_XOR, 32'd3, 32'd5, 32'd4, 32'd4, 1'b0);
    set_req(1, 1'b0, OP_EQ_B, 32'd1, 32'd1, 32'd4, 32'd4, 1'b0);
    repeat (3) step;
    chk("end_valid", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
